// File: rtl/mac_r_gmii_tte_if.sv
// mac_r_gmii_tte_if: GMII receive byte stream plus data/pointer FIFO write ports
//   master: the receive MAC (samples rx_*, FIFO status; drives FIFO writes)
//   slave : the PHY/FIFO side
interface mac_r_gmii_tte_if;
    logic        rx_vld;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rx_d;
    logic        data_fifo_wr;
    logic [7:0]  data_fifo_dout;
    logic [11:0] data_fifo_depth;
    logic        ptr_fifo_wr;
    logic [15:0] ptr_fifo_dout;
    logic        ptr_fifo_full;
    modport master(
        input  rx_vld, rx_dv, rx_er, rx_d, data_fifo_depth, ptr_fifo_full,
        output data_fifo_wr, data_fifo_dout, ptr_fifo_wr, ptr_fifo_dout
    );
    modport slave(
        output rx_vld, rx_dv, rx_er, rx_d, data_fifo_depth, ptr_fifo_full,
        input  data_fifo_wr, data_fifo_dout, ptr_fifo_wr, ptr_fifo_dout
    );
endinterface

// File: rtl/mac_r_gmii_tte.sv
// mac_r_gmii_tte: GMII receive MAC - strips preamble/SFD, checks FCS/length, fills data and pointer FIFOs
//   clk, rst            : system clock, synchronous active-high reset
//   bus (master)        : rx_vld/rx_dv/rx_er/rx_d in; data FIFO write + depth; pointer FIFO write + full
//   frame_cnt/err_cnt/drop_cnt : saturating good / errored / dropped frame counters
module mac_r_gmii_tte #(
    parameter logic [15:0] TTE_ETYPE    = 16'h891D,
    parameter int          MIN_LEN      = 64,
    parameter int          MAX_LEN      = 1518,
    parameter int          DATA_HIGH_WM = 2578
) (
    input  logic              clk,
    input  logic              rst,
    mac_r_gmii_tte_if.master  bus,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt,
    output logic [15:0]       drop_cnt
);
    localparam logic [11:0] HWM    = 12'(DATA_HIGH_WM);
    localparam logic [15:0] MIN_L  = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L  = 16'(MAX_LEN);
    localparam logic [10:0] WR_MAX = 11'(MAX_LEN - 4);
    // Reflected-register form of the 32'hC704DD7B residue (bit-reversed)
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {IDLE, PRE, DATA, PTR, DROP} state_t;
    state_t state, state_nx;

    logic [31:0] crc;
    logic [15:0] tot;
    logic [10:0] wr_len;
    logic [31:0] dly;
    logic [2:0]  dcnt;
    logic        err, tte, ety_hi;
    logic        sfd, full, err_final, take;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] v);
        return v == 16'hFFFF ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_nx  = state;
        sfd       = bus.rx_vld && state == PRE && bus.rx_dv && !bus.rx_er && bus.rx_d == 8'hD5;
        full      = bus.ptr_fifo_full || bus.data_fifo_depth > HWM;
        take      = bus.rx_vld && state == DATA && bus.rx_dv;
        err_final = err || crc != RESIDUE || tot < MIN_L || tot > MAX_L;
        if (bus.rx_vld) begin
            case (state)
                IDLE: if (bus.rx_dv && bus.rx_d == 8'h55) state_nx = PRE;
                PRE: begin
                    if (!bus.rx_dv)                state_nx = IDLE;
                    else if (bus.rx_er)            state_nx = DROP;
                    else if (bus.rx_d == 8'h55)    state_nx = PRE;
                    else if (sfd && !full)         state_nx = DATA;
                    else                           state_nx = DROP;
                end
                DATA: if (!bus.rx_dv) state_nx = PTR;
                DROP: if (!bus.rx_dv) state_nx = IDLE;
                default: ;
            endcase
        end
        if (state == PTR) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            crc                <= '1;
            tot                <= '0;
            wr_len             <= '0;
            dly                <= '0;
            dcnt               <= '0;
            err                <= 1'b0;
            tte                <= 1'b0;
            ety_hi             <= 1'b0;
            bus.data_fifo_wr   <= 1'b0;
            bus.data_fifo_dout <= '0;
            bus.ptr_fifo_wr    <= 1'b0;
            bus.ptr_fifo_dout  <= '0;
            frame_cnt          <= '0;
            err_cnt            <= '0;
            drop_cnt           <= '0;
        end else begin
            state            <= state_nx;
            bus.data_fifo_wr <= 1'b0;
            bus.ptr_fifo_wr  <= 1'b0;
            if (sfd) begin
                crc    <= '1;
                tot    <= '0;
                wr_len <= '0;
                dcnt   <= '0;
                err    <= 1'b0;
                tte    <= 1'b0;
                ety_hi <= 1'b0;
                if (full) drop_cnt <= sat(drop_cnt);
            end
            if (take) begin
                crc <= crc_byte(crc, bus.rx_d);
                tot <= sat(tot);
                dly <= {dly[23:0], bus.rx_d};
                // Four-byte lag keeps the FCS out of the data FIFO
                if (dcnt != 3'd4) dcnt <= dcnt + 3'd1;
                else if (wr_len != WR_MAX) begin
                    bus.data_fifo_wr   <= 1'b1;
                    bus.data_fifo_dout <= dly[31:24];
                    wr_len             <= wr_len + 11'd1;
                end
                if (bus.rx_er) err <= 1'b1;
                if (tot == 16'd12) ety_hi <= bus.rx_d == TTE_ETYPE[15:8];
                if (tot == 16'd13 && ety_hi && bus.rx_d == TTE_ETYPE[7:0]) tte <= 1'b1;
            end
            if (state == PTR) begin
                if (wr_len != 11'd0) begin
                    bus.ptr_fifo_wr   <= 1'b1;
                    bus.ptr_fifo_dout <= {err_final, tte, 3'b000, wr_len};
                    if (err_final) err_cnt <= sat(err_cnt);
                    else frame_cnt <= sat(frame_cnt);
                end else err_cnt <= sat(err_cnt);
            end
        end
    end
endmodule

// File: tb/tb_mac_r_gmii_tte.sv
// tb_mac_r_gmii_tte: table-driven scoreboard bench for the GMII receive MAC
module tb_mac_r_gmii_tte;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] frame_cnt, err_cnt, drop_cnt;
    int          tests = 0;
    int          fails = 0;
    int          fc = 0, ec = 0, dc = 0;
    logic [7:0]  dq[$];
    logic [15:0] pq[$];

    mac_r_gmii_tte_if bus();

    mac_r_gmii_tte dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .frame_cnt(frame_cnt),
        .err_cnt(err_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        bit          tte;
        bit          bad;
        int          er_at;
        logic [11:0] depth;
        bit          pfull;
        int          kind;
        logic [15:0] ptr;
    } vec_t;

    vec_t v[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.data_fifo_wr === 1'b1) begin
            if (dq.size() == 0) chk("data_unexpected", 32'(bus.data_fifo_wr), 0);
            else chk("data_byte", 32'(bus.data_fifo_dout), 32'(dq.pop_front()));
        end
        if (bus.ptr_fifo_wr === 1'b1) begin
            chk("ptr_after_data", dq.size(), 0);
            if (pq.size() == 0) chk("ptr_unexpected", 32'(bus.ptr_fifo_wr), 0);
            else chk("ptr_word", 32'(bus.ptr_fifo_dout), 32'(pq.pop_front()));
        end
    end

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        while ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bus.rx_vld = 1'b0;
            bus.rx_dv  = 1'($urandom);
            bus.rx_er  = 1'($urandom);
            bus.rx_d   = 8'($urandom);
        end
        @(negedge clk);
        bus.rx_vld = 1'b1;
        bus.rx_dv  = dv;
        bus.rx_er  = er;
        bus.rx_d   = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.rx_vld = 1'b0;
            bus.rx_dv  = 1'b0;
            bus.rx_er  = 1'b0;
        end
    endtask

    task automatic send(input int len, input bit tte, input bit bad, input int er_at,
                        input int kind, input int rst_at, input logic [15:0] ptr);
        logic [7:0]  f[$];
        logic [31:0] c;
        logic [7:0]  b;
        c = '1;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if (i == 12) b = tte ? 8'h89 : (b == 8'h89 ? 8'h00 : b);
            if (i == 13 && tte) b = 8'h1D;
            f.push_back(b);
            c = crc_upd(c, b);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
        if (bad) f[f.size()-1] = ~f[f.size()-1];
        if (kind == 0) begin
            if (rst_at < 0) begin
                for (int i = 0; i < (len < 1514 ? len : 1514); i++) dq.push_back(f[i]);
                pq.push_back(ptr);
            end else for (int i = 0; i < rst_at - 4; i++) dq.push_back(f[i]);
        end
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        if (kind == 2) drive(1'b1, 1'b0, 8'h12);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < f.size(); i++) begin
            if (i == rst_at) begin
                @(negedge clk);
                bus.rx_vld = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            drive(1'b1, 1'(i == er_at), f[i]);
        end
        drive(1'b0, 1'b0, 8'h00);
        idle(4);
    endtask

    task automatic settle(input string name);
        for (int k = 0; k < 100 && (dq.size() != 0 || pq.size() != 0); k++) @(negedge clk);
        chk({name, "_drain"}, dq.size() + pq.size(), 0);
        chk({name, "_frame_cnt"}, 32'(frame_cnt), fc);
        chk({name, "_err_cnt"}, 32'(err_cnt), ec);
        chk({name, "_drop_cnt"}, 32'(drop_cnt), dc);
    endtask

    initial begin
        v[0]  = '{60,   1'b0, 1'b0, -1, 12'd0,    1'b0, 0, 16'h003C};
        v[1]  = '{300,  1'b1, 1'b0, -1, 12'd0,    1'b0, 0, 16'h412C};
        v[2]  = '{60,   1'b0, 1'b1, -1, 12'd0,    1'b0, 0, 16'h803C};
        v[3]  = '{100,  1'b0, 1'b0, -1, 12'd2579, 1'b0, 1, 16'h0000};
        v[4]  = '{100,  1'b0, 1'b0, -1, 12'd0,    1'b0, 0, 16'h0064};
        v[5]  = '{1600, 1'b0, 1'b0, -1, 12'd0,    1'b0, 0, 16'h85EA};
        v[6]  = '{36,   1'b0, 1'b0, -1, 12'd0,    1'b0, 0, 16'h8024};
        v[7]  = '{100,  1'b0, 1'b0, 30, 12'd0,    1'b0, 0, 16'h8064};
        v[8]  = '{100,  1'b0, 1'b0, -1, 12'd0,    1'b1, 1, 16'h0000};
        v[9]  = '{60,   1'b0, 1'b0, -1, 12'd2578, 1'b0, 0, 16'h003C};
        v[10] = '{1514, 1'b0, 1'b0, -1, 12'd0,    1'b0, 0, 16'h05EA};
        v[11] = '{80,   1'b0, 1'b0, -1, 12'd0,    1'b0, 2, 16'h0000};

        bus.rx_vld = 1'b0;
        bus.rx_dv = 1'b0;
        bus.rx_er = 1'b0;
        bus.rx_d = 8'h00;
        bus.data_fifo_depth = 12'd0;
        bus.ptr_fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data_wr", 32'(bus.data_fifo_wr), 0);
        chk("rst_ptr_wr", 32'(bus.ptr_fifo_wr), 0);
        chk("rst_ptr_dout", 32'(bus.ptr_fifo_dout), 0);
        chk("rst_counters", {frame_cnt, err_cnt | drop_cnt}, 0);
        rst = 1'b0;
        idle(3);

        for (int n = 0; n < 12; n++) begin
            bus.data_fifo_depth = v[n].depth;
            bus.ptr_fifo_full = v[n].pfull;
            send(v[n].len, v[n].tte, v[n].bad, v[n].er_at, v[n].kind, -1, v[n].ptr);
            if (v[n].kind == 1) dc++;
            else if (v[n].kind == 0) begin
                if (v[n].ptr[15]) ec++;
                else fc++;
            end
            settle($sformatf("vec%0d", n));
        end

        bus.data_fifo_depth = 12'd0;
        bus.ptr_fifo_full = 1'b0;
        send(100, 1'b0, 1'b0, -1, 0, 50, 16'h0000);
        fc = 0;
        ec = 0;
        dc = 0;
        idle(3);
        settle("mid_rst");
        send(60, 1'b0, 1'b0, -1, 0, -1, 16'h003C);
        fc++;
        settle("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
